// File: rtl/lsu_wb_ctrl_pkg.sv
// Shared types for the MEM/WB control path: writeback mux select and LSU FSM states.
package lsu_wb_ctrl_pkg;

  typedef enum logic [1:0] {
    WB_JUMP = 2'b00,
    WB_ALU  = 2'b01,
    WB_MEM  = 2'b10
  } wb_sel_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_wb_ctrl.sv
// Load/store unit and writeback controller for the MEM stage: issues data-memory
// requests, stalls the pipeline while an access is in flight, and aborts on timeout.
module lsu_wb_ctrl
  import lsu_wb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic       is_load_i,
  input  logic       is_store_i,
  input  logic       is_jump_i,
  input  logic       rd_wr_i,
  output logic       dm_req_o,
  output logic       dm_we_o,
  input  logic       dm_gnt_i,
  input  logic       dm_rvalid_i,
  output logic [1:0] wb_sel_o,
  output logic       reg_wr_o,
  output logic       stall_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_is_store;
  logic           r_rd_wr;

  logic           w_mem_op;
  logic           w_expire;
  wb_sel_e        w_wb_sel;

  assign w_mem_op = is_load_i | is_store_i;
  // The cycle being spent now is the TIMEOUT-th one in REQ/WAIT.
  assign w_expire = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_store <= 1'b0;
      r_rd_wr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i && w_mem_op) begin
            r_state    <= S_REQ;
            r_cnt      <= '0;
            r_is_store <= is_store_i & ~is_load_i;
            r_rd_wr    <= rd_wr_i;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CW'(1);
          if (dm_gnt_i && (r_is_store || dm_rvalid_i)) begin
            r_state <= S_WB;
          end else if (w_expire) begin
            r_state <= S_ERR;
          end else if (dm_gnt_i) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (dm_rvalid_i) begin
            r_state <= S_WB;
          end else if (w_expire) begin
            r_state <= S_ERR;
          end
        end
        S_WB, S_ERR: begin
          r_state    <= S_IDLE;
          r_is_store <= 1'b0;
          r_rd_wr    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // IDLE decodes the incoming instruction combinationally; gated by rst_n so
  // outputs sit at their quiet values for the whole reset window.
  always_comb begin
    dm_req_o = 1'b0;
    dm_we_o  = 1'b0;
    w_wb_sel = WB_ALU;
    reg_wr_o = 1'b0;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    err_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_n && valid_i) begin
          if (w_mem_op) begin
            stall_o = 1'b1;
          end else begin
            w_wb_sel = is_jump_i ? WB_JUMP : WB_ALU;
            reg_wr_o = rd_wr_i;
            done_o   = 1'b1;
          end
        end
      end
      S_REQ: begin
        dm_req_o = 1'b1;
        dm_we_o  = r_is_store;
        stall_o  = 1'b1;
      end
      S_WAIT: stall_o = 1'b1;
      S_WB: begin
        done_o = 1'b1;
        if (!r_is_store) begin
          w_wb_sel = WB_MEM;
          reg_wr_o = r_rd_wr;
        end
      end
      S_ERR: begin
        err_o   = 1'b1;
        stall_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign wb_sel_o = w_wb_sel;

endmodule

// File: doc/lsu_wb_ctrl.md
LSU_WB_CTRL -- requirements
Module: lsu_wb_ctrl

Interface
- REQ-001: Parameter TIMEOUT, default 15, is the maximum number of cycles spent in REQ or WAIT before the access is aborted.
- REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-003: rst_n  input  1  asynchronous active-low reset.
- REQ-004: valid_i  input  1  MEM-stage instruction valid.
- REQ-005: is_load_i  input  1  instruction is a load.
- REQ-006: is_store_i  input  1  instruction is a store.
- REQ-007: is_jump_i  input  1  instruction is JAL/JALR, writeback is PC+4.
- REQ-008: rd_wr_i  input  1  instruction writes rd.
- REQ-009: dm_req_o  output  1  data-memory request.
- REQ-010: dm_we_o  output  1  data-memory write enable, valid with dm_req_o.
- REQ-011: dm_gnt_i  input  1  memory accepted the request.
- REQ-012: dm_rvalid_i  input  1  load data valid on rdata.
- REQ-013: wb_sel_o  output  2  writeback mux select: 00 jump/PC+4, 01 ALU result, 10 load data.
- REQ-014: reg_wr_o  output  1  register-file write enable.
- REQ-015: stall_o  output  1  freeze upstream pipeline stages.
- REQ-016: done_o  output  1  one-cycle pulse when the MEM-stage instruction retires.
- REQ-017: err_o  output  1  one-cycle pulse on a memory timeout.

Function
- REQ-018: The FSM SHALL have the states IDLE, REQ, WAIT, WB and ERR.
- REQ-019: In IDLE with valid_i=1 and neither is_load_i nor is_store_i set, outputs SHALL be combinational in the same cycle: wb_sel_o=00 if is_jump_i else 01, reg_wr_o=rd_wr_i, done_o=1, stall_o=0. The state SHALL remain IDLE.
- REQ-020: In IDLE with valid_i=1 and is_load_i or is_store_i set, the block SHALL assert stall_o=1 and reg_wr_o=0, latch op (load/store) and rd_wr_i, and go to REQ.
- REQ-021: If is_load_i and is_store_i are both set, the op SHALL be treated as a load.
- REQ-022: In IDLE with valid_i=0, outputs SHALL be wb_sel_o=01, reg_wr_o=0, stall_o=0, done_o=0.
- REQ-023: In REQ, dm_req_o=1 and dm_we_o=latched store. On dm_gnt_i: a store SHALL go to WB; a load with dm_rvalid_i=1 in the same cycle SHALL go to WB; any other load SHALL go to WAIT.
- REQ-024: In WAIT, dm_req_o=0. On dm_rvalid_i the state SHALL go to WB.
- REQ-025: stall_o SHALL be 1 in REQ, WAIT and ERR, and 0 in WB.
- REQ-026: In WB, done_o=1 and the state SHALL return to IDLE. For a load: wb_sel_o=10, reg_wr_o=latched rd_wr. For a store: wb_sel_o=01, reg_wr_o=0.
- REQ-027: A timeout counter of width $clog2(TIMEOUT+1) SHALL clear on entry to REQ and increment each cycle in REQ or WAIT. When it reaches TIMEOUT without the exiting event, the state SHALL go to ERR.
- REQ-028: In ERR, err_o=1, reg_wr_o=0, done_o=0, and the state SHALL return to IDLE.
- REQ-029: valid_i and the is_*/rd_wr inputs SHALL be ignored outside IDLE.
- REQ-030: dm_gnt_i and dm_rvalid_i SHALL be ignored in states that do not consume them.
- REQ-031: Minimum load latency is IDLE to WB in 2 cycles (gnt and rvalid together). Minimum store latency is 2 cycles.

Reset
- REQ-032: While rst_n=0, state SHALL be IDLE and the counter and latched flags SHALL be 0.
- REQ-033: Reset outputs: dm_req_o=0, dm_we_o=0, wb_sel_o=01, reg_wr_o=0, stall_o=0, done_o=0, err_o=0.
- REQ-034: Reset asserted mid-access SHALL abort the access immediately, with no pending write or register write after release.

Structure
- REQ-035: A shared package SHALL define the wb_sel enum (WB_JUMP=00, WB_ALU=01, WB_MEM=10) and the FSM state enum, both shared with the writeback mux and the decoder.
- REQ-036: The block SHALL be one module with no sub-modules; the timeout counter is inline.

Verification
- REQ-037: ALU op: valid_i=1, rd_wr_i=1, no memory op -> same cycle wb_sel_o=01, reg_wr_o=1, done_o=1, stall_o=0.
- REQ-038: Jump: valid_i=1, is_jump_i=1 -> wb_sel_o=00, reg_wr_o=1, done_o=1.
- REQ-039: Load with gnt after 2 cycles in REQ and rvalid 1 cycle after gnt -> stall_o high for 4 cycles, then WB with wb_sel_o=10, reg_wr_o=1, done_o=1.
- REQ-040: Store with immediate gnt -> dm_req_o=1 and dm_we_o=1 for 1 cycle, then WB with reg_wr_o=0 and done_o=1.
- REQ-041: Load with no rvalid and TIMEOUT=4 -> ERR after 4 counted cycles, err_o pulse, reg_wr_o=0, return to IDLE.
- REQ-042: rst_n dropped while in WAIT -> outputs immediately at reset values; a late dm_rvalid_i after release causes no reg_wr_o.
